// File: rtl/pac_pkg.sv
// Shared definitions for the packet action controller: header/action codes,
// field offsets, FSM state type and the action-to-port-mask decode.
package pac_pkg;

  localparam int DW    = 134;
  localparam int ACT_W = 11;
  localparam int NPORT = 3;

  localparam logic [1:0] HDR_FIRST = 2'b01;
  localparam logic [1:0] HDR_MID   = 2'b11;
  localparam logic [1:0] HDR_LAST  = 2'b10;

  localparam logic [1:0] ACT_UNI = 2'b00;
  localparam logic [1:0] ACT_BC  = 2'b10;

  localparam int HDR_HI      = 133;
  localparam int HDR_LO      = 132;
  localparam int ACT_TYPE_HI = 10;
  localparam int ACT_TYPE_LO = 9;
  localparam int ACT_PKT_HI  = 8;
  localparam int ACT_PKT_LO  = 6;
  localparam int ACT_PORT_HI = 5;
  localparam int ACT_PORT_LO = 0;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    WAIT_S = 2'd1,
    SEND_S = 2'd2,
    DROP_S = 2'd3
  } pac_state_e;

  // Unknown action types and out-of-range unicast ports decode to an empty mask.
  function automatic logic [NPORT-1:0] decode_mask(input logic [1:0] act_type,
                                                   input logic [5:0] port);
    logic [NPORT-1:0] m;
    m = '0;
    case (act_type)
      ACT_UNI: if (port <= 6'd2) m = 3'b001 << port[1:0];
      ACT_BC:  m = 3'b100 | (3'b001 << port[0]);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pac_sfifo.sv
// Synchronous show-ahead FIFO; simultaneous read and write are accepted at any
// fill level, including full.
module pac_sfifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/pac.sv
// Packet action controller: buffers packets with their action/valid words and
// replicates each packet to the decoded egress ports, or drops it.
module pac
  import pac_pkg::*;
#(
  parameter int DATA_AW       = 8,
  parameter int ACT_AW        = 4,
  parameter int PKT_MAX_BEATS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     in_pac_data,
  input  logic              in_pac_data_wr,
  input  logic              in_pac_valid,
  input  logic              in_pac_valid_wr,
  input  logic [ACT_W-1:0]  in_pac_action,
  input  logic              in_pac_action_wr,
  output logic [DW-1:0]     out_port0_data,
  output logic              out_port0_data_wr,
  output logic              out_port0_valid,
  output logic              out_port0_valid_wr,
  output logic [DW-1:0]     out_port1_data,
  output logic              out_port1_data_wr,
  output logic              out_port1_valid,
  output logic              out_port1_valid_wr,
  output logic [DW-1:0]     out_port2_data,
  output logic              out_port2_data_wr,
  output logic              out_port2_valid,
  output logic              out_port2_valid_wr,
  input  logic              in_port0_alf,
  input  logic              in_port1_alf,
  input  logic              in_port2_alf,
  output logic [31:0]       drop_cnt
);

  localparam logic [DATA_AW:0] ROOM_LIMIT = (DATA_AW+1)'((1 << DATA_AW) - PKT_MAX_BEATS);

  logic [1:0]        in_hdr;
  logic              in_pkt;
  logic              cur_acc;
  logic              sop;
  logic              admit;
  logic              beat_ok;
  logic              ing_drop;

  logic [DW-1:0]     data_rdata;
  logic              data_full, data_empty;
  logic [DATA_AW:0]  data_count;
  logic [ACT_W-1:0]  act_rdata;
  logic              act_full, act_empty;
  logic [ACT_AW:0]   unused_act_count;
  logic              val_rdata;
  logic              val_full, val_empty;
  logic [ACT_AW:0]   unused_val_count;

  pac_state_e        state_q, state_d;
  logic [NPORT-1:0]  mask_q;
  logic [NPORT-1:0]  alf;
  logic              pop, data_rd, send_beat, fsm_drop, last_beat;

  logic [DW-1:0]     port_data [NPORT];
  logic [NPORT-1:0]  port_wr;
  logic [NPORT-1:0]  port_vld;

  logic [2:0]        unused_pkttype;
  logic              unused_data_full;

  // Ingress admission: decided at start of packet; a one-beat packet starts with HDR_LAST.
  assign in_hdr   = in_pac_data[HDR_HI:HDR_LO];
  assign sop      = in_pac_data_wr && ((in_hdr == HDR_FIRST) || !in_pkt);
  assign admit    = (data_count <= ROOM_LIMIT) && !act_full && !val_full;
  assign beat_ok  = sop ? admit : cur_acc;
  assign ing_drop = sop && !admit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt  <= 1'b0;
      cur_acc <= 1'b0;
    end else begin
      if (in_pac_data_wr) in_pkt <= (in_hdr != HDR_LAST);
      if (sop) cur_acc <= admit;
    end
  end

  pac_sfifo #(.W(DW), .AW(DATA_AW)) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (in_pac_data_wr && beat_ok),
    .wdata (in_pac_data),
    .rd    (data_rd),
    .rdata (data_rdata),
    .full  (data_full),
    .empty (data_empty),
    .count (data_count)
  );

  pac_sfifo #(.W(ACT_W), .AW(ACT_AW)) u_act_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (in_pac_action_wr && beat_ok),
    .wdata (in_pac_action),
    .rd    (pop),
    .rdata (act_rdata),
    .full  (act_full),
    .empty (act_empty),
    .count (unused_act_count)
  );

  // A valid strobe alongside a fresh multi-beat first beat belongs to the previous packet.
  pac_sfifo #(.W(1), .AW(ACT_AW)) u_val_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (in_pac_valid_wr && ((sop && in_hdr == HDR_LAST) ? admit : cur_acc)),
    .wdata (in_pac_valid),
    .rd    (pop),
    .rdata (val_rdata),
    .full  (val_full),
    .empty (val_empty),
    .count (unused_val_count)
  );

  assign unused_pkttype   = act_rdata[ACT_PKT_HI:ACT_PKT_LO];
  assign unused_data_full = data_full;

  assign alf       = {in_port2_alf, in_port1_alf, in_port0_alf};
  assign last_beat = (data_rdata[HDR_HI:HDR_LO] == HDR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE_S;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    data_rd   = 1'b0;
    send_beat = 1'b0;
    fsm_drop  = 1'b0;
    case (state_q)
      IDLE_S: if (!act_empty && !val_empty) begin
        pop     = 1'b1;
        state_d = WAIT_S;
      end
      WAIT_S: if (mask_q == '0) begin
        fsm_drop = 1'b1;
        state_d  = DROP_S;
      end else if ((mask_q & alf) == '0) begin
        state_d = SEND_S;
      end
      SEND_S: if (!data_empty) begin
        data_rd   = 1'b1;
        send_beat = 1'b1;
        if (last_beat) state_d = IDLE_S;
      end
      DROP_S: if (!data_empty) begin
        data_rd = 1'b1;
        if (last_beat) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      port_wr  <= '0;
      port_vld <= '0;
      for (int p = 0; p < NPORT; p++) port_data[p] <= '0;
    end else begin
      if (pop) begin
        mask_q <= decode_mask(act_rdata[ACT_TYPE_HI:ACT_TYPE_LO],
                              act_rdata[ACT_PORT_HI:ACT_PORT_LO]) & {NPORT{val_rdata}};
      end
      for (int p = 0; p < NPORT; p++) begin
        port_wr[p]   <= send_beat && mask_q[p];
        port_vld[p]  <= send_beat && mask_q[p] && last_beat;
        port_data[p] <= (send_beat && mask_q[p]) ? data_rdata : '0;
      end
    end
  end

  // Ingress and FSM drops can land in the same cycle, so the step can be 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      logic [32:0] sum;
      sum = {1'b0, drop_cnt} + 33'(ing_drop) + 33'(fsm_drop);
      drop_cnt <= sum[32] ? '1 : sum[31:0];
    end
  end

  assign out_port0_data     = port_data[0];
  assign out_port0_data_wr  = port_wr[0];
  assign out_port0_valid    = port_vld[0];
  assign out_port0_valid_wr = port_vld[0];
  assign out_port1_data     = port_data[1];
  assign out_port1_data_wr  = port_wr[1];
  assign out_port1_valid    = port_vld[1];
  assign out_port1_valid_wr = port_vld[1];
  assign out_port2_data     = port_data[2];
  assign out_port2_data_wr  = port_wr[2];
  assign out_port2_valid    = port_vld[2];
  assign out_port2_valid_wr = port_vld[2];

endmodule

// File: tb/tb_pac.sv
// Directed self-checking bench for pac: unicast, broadcast, discard,
// backpressure, overflow and mid-packet reset.
module tb_pac;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [133:0] in_pac_data = '0;
  logic         in_pac_data_wr = 1'b0;
  logic         in_pac_valid = 1'b0;
  logic         in_pac_valid_wr = 1'b0;
  logic [10:0]  in_pac_action = '0;
  logic         in_pac_action_wr = 1'b0;
  logic [133:0] out_port0_data, out_port1_data, out_port2_data;
  logic         out_port0_data_wr, out_port1_data_wr, out_port2_data_wr;
  logic         out_port0_valid, out_port1_valid, out_port2_valid;
  logic         out_port0_valid_wr, out_port1_valid_wr, out_port2_valid_wr;
  logic         in_port0_alf = 1'b0, in_port1_alf = 1'b0, in_port2_alf = 1'b0;
  logic [31:0]  drop_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [133:0] q0[$], q1[$], q2[$];
  int           t1[$], t2[$];
  logic [133:0] lastv2;
  int           vcnt0, vcnt1, vcnt2;

  always #5 clk = ~clk;

  pac dut (
    .clk(clk), .rst_n(rst_n),
    .in_pac_data(in_pac_data), .in_pac_data_wr(in_pac_data_wr),
    .in_pac_valid(in_pac_valid), .in_pac_valid_wr(in_pac_valid_wr),
    .in_pac_action(in_pac_action), .in_pac_action_wr(in_pac_action_wr),
    .out_port0_data(out_port0_data), .out_port0_data_wr(out_port0_data_wr),
    .out_port0_valid(out_port0_valid), .out_port0_valid_wr(out_port0_valid_wr),
    .out_port1_data(out_port1_data), .out_port1_data_wr(out_port1_data_wr),
    .out_port1_valid(out_port1_valid), .out_port1_valid_wr(out_port1_valid_wr),
    .out_port2_data(out_port2_data), .out_port2_data_wr(out_port2_data_wr),
    .out_port2_valid(out_port2_valid), .out_port2_valid_wr(out_port2_valid_wr),
    .in_port0_alf(in_port0_alf), .in_port1_alf(in_port1_alf), .in_port2_alf(in_port2_alf),
    .drop_cnt(drop_cnt)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (out_port0_data_wr) q0.push_back(out_port0_data);
      if (out_port1_data_wr) begin q1.push_back(out_port1_data); t1.push_back(cyc); end
      if (out_port2_data_wr) begin q2.push_back(out_port2_data); t2.push_back(cyc); end
      if (out_port0_valid_wr) vcnt0++;
      if (out_port1_valid_wr) vcnt1++;
      if (out_port2_valid_wr) begin vcnt2++; lastv2 = out_port2_data; end
    end
  end

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [133:0] beat(input int id, input int b, input int nb);
    logic [1:0] hdr;
    if (b == nb - 1)  hdr = 2'b10;
    else if (b == 0)  hdr = 2'b01;
    else              hdr = 2'b11;
    return {hdr, 132'(id * 256 + b)};
  endfunction

  task automatic send_pkt(input int id, input int nb, input logic [10:0] act, input logic vld);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      in_pac_data      = beat(id, b, nb);
      in_pac_data_wr   = 1'b1;
      in_pac_action    = act;
      in_pac_action_wr = (b == 0);
      in_pac_valid     = vld;
      in_pac_valid_wr  = (b == nb - 1);
    end
    @(negedge clk);
    in_pac_data_wr   = 1'b0;
    in_pac_action_wr = 1'b0;
    in_pac_valid_wr  = 1'b0;
  endtask

  task automatic clear_mon();
    q0.delete(); q1.delete(); q2.delete(); t1.delete(); t2.delete();
    vcnt0 = 0; vcnt1 = 0; vcnt2 = 0; lastv2 = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    clear_mon();
    idle(3);
    check("reset_wr", 134'({out_port0_data_wr, out_port1_data_wr, out_port2_data_wr}), 134'(0));
    check("reset_data", out_port0_data | out_port1_data | out_port2_data, 134'(0));
    check("reset_drop", 134'(drop_cnt), 134'(0));
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // unicast to port2
    send_pkt(1, 4, 11'h002, 1'b1);
    idle(20);
    check("uni_cnt2", 134'(q2.size()), 134'(4));
    check("uni_cnt01", 134'(q0.size() + q1.size()), 134'(0));
    for (int b = 0; b < 4; b++)
      if (b < q2.size()) check($sformatf("uni_beat%0d", b), q2[b], beat(1, b, 4));
    check("uni_vwr", 134'(vcnt2), 134'(1));
    check("uni_vbeat", lastv2, beat(1, 3, 4));
    check("uni_drop", 134'(drop_cnt), 134'(0));

    // broadcast to ports 1 and 2
    clear_mon();
    send_pkt(2, 3, 11'h401, 1'b1);
    idle(20);
    check("bc_cnt1", 134'(q1.size()), 134'(3));
    check("bc_cnt2", 134'(q2.size()), 134'(3));
    check("bc_cnt0", 134'(q0.size()), 134'(0));
    for (int b = 0; b < 3; b++)
      if (b < q1.size() && b < q2.size()) begin
        check($sformatf("bc_p1_%0d", b), q1[b], beat(2, b, 3));
        check($sformatf("bc_p2_%0d", b), q2[b], beat(2, b, 3));
        check($sformatf("bc_time%0d", b), 134'(t1[b]), 134'(t2[b]));
      end

    // discard, then a normal packet to port0
    clear_mon();
    send_pkt(3, 5, 11'h000, 1'b0);
    idle(20);
    check("disc_egress", 134'(q0.size() + q1.size() + q2.size()), 134'(0));
    check("disc_drop", 134'(drop_cnt), 134'(1));
    send_pkt(4, 2, 11'h000, 1'b1);
    idle(15);
    check("disc_next_cnt", 134'(q0.size()), 134'(2));
    if (q0.size() > 1) check("disc_next_beat", q0[1], beat(4, 1, 2));

    // backpressure on port0
    clear_mon();
    in_port0_alf = 1'b1;
    send_pkt(5, 3, 11'h000, 1'b1);
    idle(10);
    check("bp_hold", 134'(q0.size()), 134'(0));
    in_port0_alf = 1'b0;
    k = 0;
    while (!out_port0_data_wr && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("bp_start_lat", 134'(k <= 2), 134'(1));
    in_port0_alf = 1'b1;
    idle(10);
    check("bp_nostall", 134'(q0.size()), 134'(3));
    if (q0.size() > 2) check("bp_last", q0[2], beat(5, 2, 3));
    in_port0_alf = 1'b0;
    idle(3);

    // overflow: one packet parks in the FSM, then 17 more arrive with ports blocked
    clear_mon();
    in_port0_alf = 1'b1; in_port1_alf = 1'b1; in_port2_alf = 1'b1;
    send_pkt(100, 1, 11'h000, 1'b1);
    idle(5);
    for (int i = 0; i < 17; i++) send_pkt(101 + i, 1, 11'h000, 1'b1);
    idle(3);
    check("ovf_drop", 134'(drop_cnt), 134'(2));
    check("ovf_hold", 134'(q0.size()), 134'(0));
    in_port0_alf = 1'b0; in_port1_alf = 1'b0; in_port2_alf = 1'b0;
    idle(120);
    check("ovf_cnt", 134'(q0.size()), 134'(17));
    for (int i = 0; i < 17; i++)
      if (i < q0.size()) check($sformatf("ovf_order%0d", i), q0[i], beat(100 + i, 0, 1));

    // reset in the middle of SEND_S
    clear_mon();
    send_pkt(200, 10, 11'h001, 1'b1);
    k = 0;
    while (!out_port1_data_wr && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_started", 134'(out_port1_data_wr), 134'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wr", 134'({out_port0_data_wr, out_port1_data_wr, out_port2_data_wr,
                          out_port0_valid_wr, out_port1_valid_wr, out_port2_valid_wr}), 134'(0));
    check("rst_data", out_port0_data | out_port1_data | out_port2_data, 134'(0));
    check("rst_drop", 134'(drop_cnt), 134'(0));
    idle(3);
    rst_n = 1'b1;
    clear_mon();
    idle(30);
    check("rst_residual", 134'(q0.size() + q1.size() + q2.size()), 134'(0));
    send_pkt(201, 2, 11'h001, 1'b1);
    idle(15);
    check("rst_after_cnt", 134'(q1.size()), 134'(2));
    if (q1.size() > 0) check("rst_after_beat", q1[0], beat(201, 0, 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
